// File: rtl/player_controller_if.sv
// Bundles the button inputs, rectangle block flags and player outputs that
// pass between the player controller and the rest of the game.
interface player_controller_if #(
  parameter int N_RECT = 4
);
  logic [3:0]        btns;
  logic              btnC;
  logic [N_RECT-1:0] upEnable;
  logic [N_RECT-1:0] downEnable;
  logic [N_RECT-1:0] leftEnable;
  logic [N_RECT-1:0] rightEnable;
  logic [9:0]        player_hPos;
  logic [9:0]        player_vPos;
  logic [3:0]        player_color;
  logic              moved;
  logic [1:0]        state_o;

  modport master (
    output btns, btnC, upEnable, downEnable, leftEnable, rightEnable,
    input  player_hPos, player_vPos, player_color, moved, state_o
  );

  modport slave (
    input  btns, btnC, upEnable, downEnable, leftEnable, rightEnable,
    output player_hPos, player_vPos, player_color, moved, state_o
  );
endinterface

// File: rtl/player_controller.sv
// Player sprite position/colour owner: turns held direction buttons into
// single steps plus auto-repeat, honouring rectangle block flags and screen edges.
module player_controller #(
  parameter int N_RECT       = 4,
  parameter int pWidth       = 12,
  parameter int pHeight      = 12,
  parameter int H_MAX        = 640,
  parameter int V_MAX        = 480,
  parameter int H_INIT       = 314,
  parameter int V_INIT       = 234,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int NUM_COLORS   = 4
) (
  input logic btnClk,
  input logic rst,
  player_controller_if.slave bus
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } stateT;

  stateT       state;
  logic [CW-1:0] cnt;
  logic [3:0]  dir;
  logic [9:0]  hPos;
  logic [9:0]  vPos;
  logic [3:0]  color;
  logic        moved;
  logic        btnCPrev;

  logic [N_RECT-1:0] upFlags, downFlags, leftFlags, rightFlags;
  logic [3:0]  btns;
  logic        blkU, blkD, blkL, blkR;
  logic        oneHot, lockReq, stepNow, canMove;
  logic [9:0]  nextH, nextV;

  assign btns       = bus.btns;
  assign upFlags    = bus.upEnable;
  assign downFlags  = bus.downEnable;
  assign leftFlags  = bus.leftEnable;
  assign rightFlags = bus.rightEnable;
  assign blkU = |upFlags;
  assign blkD = |downFlags;
  assign blkL = |leftFlags;
  assign blkR = |rightFlags;

  assign oneHot  = (btns == 4'b1000) || (btns == 4'b0100) ||
                   (btns == 4'b0010) || (btns == 4'b0001);
  assign lockReq = (btns != 4'b0000) && !oneHot;

  // Candidate one-pixel move; edge limits are evaluated in 11 bits so the sum never wraps.
  always_comb begin
    canMove = 1'b0;
    nextH   = hPos;
    nextV   = vPos;
    case (btns)
      4'b1000: if (vPos != 10'd0 && !blkU) begin
        canMove = 1'b1;
        nextV   = vPos - 10'd1;
      end
      4'b0100: if ((({1'b0, vPos}) + 11'(pHeight)) < 11'(V_MAX) && !blkD) begin
        canMove = 1'b1;
        nextV   = vPos + 10'd1;
      end
      4'b0010: if ((({1'b0, hPos}) + 11'(pWidth)) < 11'(H_MAX) && !blkR) begin
        canMove = 1'b1;
        nextH   = hPos + 10'd1;
      end
      4'b0001: if (hPos != 10'd0 && !blkL) begin
        canMove = 1'b1;
        nextH   = hPos - 10'd1;
      end
      default: canMove = 1'b0;
    endcase
  end

  // A step slot only opens while the same direction is still held.
  always_comb begin
    stepNow = 1'b0;
    if (!lockReq) begin
      case (state)
        IDLE:          stepNow = oneHot;
        DELAY, REPEAT: stepNow = (btns == dir) && (cnt == '0);
        default:       stepNow = 1'b0;
      endcase
    end
  end

  always_ff @(posedge btnClk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dir      <= 4'b0000;
      hPos     <= 10'(H_INIT);
      vPos     <= 10'(V_INIT);
      color    <= 4'd0;
      moved    <= 1'b0;
      btnCPrev <= 1'b0;
    end else begin
      moved    <= 1'b0;
      btnCPrev <= bus.btnC;
      if (bus.btnC && !btnCPrev) begin
        color <= (color == 4'(NUM_COLORS - 1)) ? 4'd0 : color + 4'd1;
      end
      if (stepNow && canMove) begin
        hPos  <= nextH;
        vPos  <= nextV;
        moved <= 1'b1;
      end
      if (lockReq) begin
        state <= LOCK;
      end else begin
        case (state)
          IDLE: if (oneHot) begin
            dir   <= btns;
            cnt   <= DELAY_LOAD;
            state <= DELAY;
          end
          DELAY: if (btns != dir) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            cnt   <= RATE_LOAD;
            state <= REPEAT;
          end else begin
            cnt <= cnt - 1'b1;
          end
          REPEAT: if (btns != dir) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            cnt <= RATE_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
          LOCK: if (btns == 4'b0000) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.player_hPos  = hPos;
  assign bus.player_vPos  = vPos;
  assign bus.player_color = color;
  assign bus.moved        = moved;
  assign bus.state_o      = state;

endmodule

// File: tb/tb_player_controller.sv
// Scoreboard bench for player_controller: a hold-count reference model pushes
// per-cycle expectations that a monitor pops and compares after each edge.
module tb_player_controller;

  localparam int N_RECT = 4;

  logic btnClk = 1'b0;
  logic rst    = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   movedSeen = 0;

  always #5 btnClk = ~btnClk;

  player_controller_if #(.N_RECT(N_RECT)) bus ();

  player_controller #(
    .N_RECT(N_RECT), .pWidth(12), .pHeight(12), .H_MAX(640), .V_MAX(480),
    .H_INIT(314), .V_INIT(234), .REPEAT_DELAY(8), .REPEAT_RATE(2), .NUM_COLORS(4)
  ) dut (
    .btnClk(btnClk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [3:0] c;
    logic       m;
    logic [1:0] s;
  } expT;

  expT sbq[$];
  expT monExp;

  // Reference model state: mHold counts consecutive cycles of one held direction (-1 = none).
  int mH, mV, mColor, mCPrev, mState, mHold, mDir;

  task automatic modelCycle();
    int  b;
    bit  oh, fire, mv;
    expT e;
    b  = int'(bus.btns);
    mv = 1'b0;
    if (rst) begin
      mH = 314; mV = 234; mColor = 0; mCPrev = 0; mState = 0; mHold = -1; mDir = 0;
    end else begin
      if (bus.btnC && mCPrev == 0) mColor = (mColor + 1) % 4;
      mCPrev = int'(bus.btnC);
      oh = (b == 1 || b == 2 || b == 4 || b == 8);
      if (b != 0 && !oh) begin
        mState = 3; mHold = -1;
      end else if (mState == 3) begin
        if (b == 0) mState = 0;
      end else if (!oh) begin
        mState = 0; mHold = -1;
      end else if (mHold >= 0 && b != mDir) begin
        mState = 0; mHold = -1;
      end else begin
        if (mHold < 0) begin
          mHold = 0; mDir = b;
        end else begin
          mHold++;
        end
        fire   = (mHold == 0) || (mHold >= 8 && ((mHold - 8) % 2) == 0);
        mState = (mHold < 8) ? 1 : 2;
        if (fire) begin
          case (b)
            8: if (mV > 0 && bus.upEnable == 0) begin mV--; mv = 1; end
            4: if (mV + 12 < 480 && bus.downEnable == 0) begin mV++; mv = 1; end
            2: if (mH + 12 < 640 && bus.rightEnable == 0) begin mH++; mv = 1; end
            1: if (mH > 0 && bus.leftEnable == 0) begin mH--; mv = 1; end
            default: mv = 0;
          endcase
        end
      end
    end
    e.h = 10'(mH); e.v = 10'(mV); e.c = 4'(mColor); e.m = mv; e.s = 2'(mState);
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      modelCycle();
      @(posedge btnClk);
      #2;
    end
  endtask

  // Monitor: pops one expectation per edge and compares every output.
  always @(posedge btnClk) begin
    #1;
    if (sbq.size() > 0) begin
      monExp = sbq.pop_front();
      if (bus.moved === 1'b1) movedSeen++;
      checks++;
      if (bus.player_hPos !== monExp.h) begin
        errors++;
        $display("[TB] FAIL sb_hPos at %0t got %0d expected %0d", $time, bus.player_hPos, monExp.h);
      end
      checks++;
      if (bus.player_vPos !== monExp.v) begin
        errors++;
        $display("[TB] FAIL sb_vPos at %0t got %0d expected %0d", $time, bus.player_vPos, monExp.v);
      end
      checks++;
      if (bus.player_color !== monExp.c) begin
        errors++;
        $display("[TB] FAIL sb_color at %0t got %0d expected %0d", $time, bus.player_color, monExp.c);
      end
      checks++;
      if (bus.moved !== monExp.m) begin
        errors++;
        $display("[TB] FAIL sb_moved at %0t got %0b expected %0b", $time, bus.moved, monExp.m);
      end
      checks++;
      if (bus.state_o !== monExp.s) begin
        errors++;
        $display("[TB] FAIL sb_state at %0t got %0d expected %0d", $time, bus.state_o, monExp.s);
      end
    end
  end

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    movedSeen = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    checks++;
    if (bus.player_hPos !== 10'd314 || bus.player_vPos !== 10'd234 || bus.state_o !== 2'd0 ||
        bus.player_color !== 4'd0 || bus.moved !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset got h=%0d v=%0d s=%0d c=%0d m=%0b expected 314/234/0/0/0",
               bus.player_hPos, bus.player_vPos, bus.state_o, bus.player_color, bus.moved);
    end
  endtask

  task automatic test_single_step();
    doReset();
    bus.btns = 4'd2;
    applyStimulus(1);
    checks++;
    if (bus.player_hPos !== 10'd315 || bus.moved !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_step got h=%0d m=%0b expected 315/1", bus.player_hPos, bus.moved);
    end
    bus.btns = 4'd0;
    applyStimulus(4);
    checks++;
    if (bus.player_hPos !== 10'd315 || bus.state_o !== 2'd0 || movedSeen != 1) begin
      errors++;
      $display("[TB] FAIL single_after got h=%0d s=%0d steps=%0d expected 315/0/1",
               bus.player_hPos, bus.state_o, movedSeen);
    end
  endtask

  task automatic test_auto_repeat();
    doReset();
    bus.btns = 4'd8;
    applyStimulus(20);
    bus.btns = 4'd0;
    applyStimulus(1);
    checks++;
    if (bus.player_vPos !== 10'd227 || movedSeen != 7) begin
      errors++;
      $display("[TB] FAIL auto_repeat got v=%0d steps=%0d expected 227/7", bus.player_vPos, movedSeen);
    end
  endtask

  task automatic test_edges();
    doReset();
    bus.btns = 4'd1;
    applyStimulus(700);
    movedSeen = 0;
    applyStimulus(20);
    checks++;
    if (bus.player_hPos !== 10'd0 || movedSeen != 0) begin
      errors++;
      $display("[TB] FAIL left_edge got h=%0d steps=%0d expected 0/0", bus.player_hPos, movedSeen);
    end
    bus.btns = 4'd0;
    doReset();
    bus.btns = 4'd4;
    applyStimulus(520);
    movedSeen = 0;
    applyStimulus(20);
    checks++;
    if (bus.player_vPos !== 10'd468 || bus.player_hPos !== 10'd314 || movedSeen != 0) begin
      errors++;
      $display("[TB] FAIL bottom_edge got v=%0d h=%0d steps=%0d expected 468/314/0",
               bus.player_vPos, bus.player_hPos, movedSeen);
    end
    bus.btns = 4'd0;
    applyStimulus(1);
  endtask

  task automatic test_blocked();
    doReset();
    bus.leftEnable = 4'b0100;
    bus.btns = 4'd1;
    applyStimulus(12);
    checks++;
    if (bus.player_hPos !== 10'd314 || movedSeen != 0) begin
      errors++;
      $display("[TB] FAIL blocked got h=%0d steps=%0d expected 314/0", bus.player_hPos, movedSeen);
    end
    bus.leftEnable = 4'b0000;
    applyStimulus(5);
    checks++;
    if (bus.player_hPos !== 10'd311) begin
      errors++;
      $display("[TB] FAIL unblocked got h=%0d expected 311", bus.player_hPos);
    end
    bus.btns = 4'd0;
    applyStimulus(1);
  endtask

  task automatic test_lock();
    doReset();
    bus.btns = 4'b1010;
    applyStimulus(3);
    checks++;
    if (bus.state_o !== 2'd3 || bus.player_hPos !== 10'd314 || bus.player_vPos !== 10'd234) begin
      errors++;
      $display("[TB] FAIL lock got s=%0d h=%0d v=%0d expected 3/314/234",
               bus.state_o, bus.player_hPos, bus.player_vPos);
    end
    bus.btns = 4'd0;
    applyStimulus(1);
    checks++;
    if (bus.state_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL lock_exit got s=%0d expected 0", bus.state_o);
    end
    bus.btns = 4'd4;
    applyStimulus(1);
    bus.btns = 4'd0;
    applyStimulus(1);
    checks++;
    if (bus.player_vPos !== 10'd235) begin
      errors++;
      $display("[TB] FAIL lock_then_down got v=%0d expected 235", bus.player_vPos);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    bus.btns = 4'd2;
    applyStimulus(1);
    bus.btns = 4'd1;
    applyStimulus(1);
    checks++;
    if (bus.player_hPos !== 10'd315 || bus.state_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL dir_change got h=%0d s=%0d expected 315/0", bus.player_hPos, bus.state_o);
    end
    applyStimulus(1);
    checks++;
    if (bus.player_hPos !== 10'd314 || bus.state_o !== 2'd1) begin
      errors++;
      $display("[TB] FAIL new_dir got h=%0d s=%0d expected 314/1", bus.player_hPos, bus.state_o);
    end
    bus.btns = 4'd0;
    applyStimulus(1);
  endtask

  task automatic test_colour_and_reset();
    logic [3:0] expSeq [5];
    expSeq = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    doReset();
    for (int i = 0; i < 5; i++) begin
      bus.btnC = 1'b1;
      applyStimulus(2);
      checks++;
      if (bus.player_color !== expSeq[i]) begin
        errors++;
        $display("[TB] FAIL colour_%0d got %0d expected %0d", i, bus.player_color, expSeq[i]);
      end
      bus.btnC = 1'b0;
      applyStimulus(1);
    end
    bus.btns = 4'd2;
    applyStimulus(12);
    checks++;
    if (bus.state_o !== 2'd2) begin
      errors++;
      $display("[TB] FAIL in_repeat got s=%0d expected 2", bus.state_o);
    end
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checks++;
    if (bus.player_hPos !== 10'd314 || bus.player_vPos !== 10'd234 ||
        bus.player_color !== 4'd0 || bus.state_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset got h=%0d v=%0d c=%0d s=%0d expected 314/234/0/0",
               bus.player_hPos, bus.player_vPos, bus.player_color, bus.state_o);
    end
    applyStimulus(1);
    checks++;
    if (bus.player_hPos !== 10'd315) begin
      errors++;
      $display("[TB] FAIL fresh_press got h=%0d expected 315", bus.player_hPos);
    end
    bus.btns = 4'd0;
    applyStimulus(1);
  endtask

  initial begin
    bus.btns        = 4'd0;
    bus.btnC        = 1'b0;
    bus.upEnable    = '0;
    bus.downEnable  = '0;
    bus.leftEnable  = '0;
    bus.rightEnable = '0;
    mH = 0; mV = 0; mColor = 0; mCPrev = 0; mState = 0; mHold = -1; mDir = 0;
    #2;
    test_reset();
    test_single_step();
    test_auto_repeat();
    test_edges();
    test_blocked();
    test_lock();
    test_back_to_back();
    test_colour_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
